// File: rtl/conv_pkg.sv
// Shared types for the activation feeder: FSM state encoding and padded-geometry helper.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic int pad_dim(input int size, input int pad);
    return size + 2 * pad;
  endfunction

endpackage

// File: rtl/pad_position_counter.sv
// Raster position over the padded frame, with a last-position flag and a pad-region decode.
// Counters move only on advance_i; clear_i restarts at (0,0). The decodes are combinational.
module pad_position_counter
  import conv_pkg::*;
#(
  parameter int IMAGE_SIZE_X = 32,
  parameter int IMAGE_SIZE_Y = 32,
  parameter int PAD          = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear_i,
  input  logic advance_i,
  output logic is_pad_o,
  output logic last_o
);

  localparam int PX = pad_dim(IMAGE_SIZE_X, PAD);
  localparam int PY = pad_dim(IMAGE_SIZE_Y, PAD);
  localparam int CW = (PX > 1) ? $clog2(PX) : 1;
  localparam int RW = (PY > 1) ? $clog2(PY) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(PX - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(PY - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (advance_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Compared as int so that PAD=0 does not produce an always-false unsigned compare.
  assign is_pad_o = (int'(row_q) < PAD) || (int'(row_q) >= PAD + IMAGE_SIZE_Y) ||
                    (int'(col_q) < PAD) || (int'(col_q) >= PAD + IMAGE_SIZE_X);
  assign last_o   = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/act_stream_feeder.sv
// Zero-pads a raster pixel stream and feeds the line buffer one padded pixel per cycle, then flushes.
// Outputs are one cycle behind the decision; hold stalls everything, and s_ready is low on pads/hold.
module act_stream_feeder
  import conv_pkg::*;
#(
  parameter int NBITS        = 8,
  parameter int NFMAPS       = 3,
  parameter int IMAGE_SIZE_X = 32,
  parameter int IMAGE_SIZE_Y = 32,
  parameter int PAD          = 1,
  parameter int WORD_SIZE    = NFMAPS * NBITS
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 frame_start,
  input  logic                 hold,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WORD_SIZE-1:0] s_act,
  output logic                 lb_valid,
  output logic                 lb_flush,
  output logic [WORD_SIZE-1:0] lb_act,
  output logic                 busy,
  output logic                 frame_done
);

  state_e state_q, state_d;
  logic   is_pad, last_pos, beat, clear;
  logic   lb_valid_q, lb_valid_d;
  logic   lb_flush_q, lb_flush_d;
  logic   frame_done_q, frame_done_d;
  logic [WORD_SIZE-1:0] lb_act_q, lb_act_d;

  pad_position_counter #(
    .IMAGE_SIZE_X(IMAGE_SIZE_X),
    .IMAGE_SIZE_Y(IMAGE_SIZE_Y),
    .PAD         (PAD)
  ) u_pos (
    .clk      (clk),
    .rstn     (rstn),
    .clear_i  (clear),
    .advance_i(beat),
    .is_pad_o (is_pad),
    .last_o   (last_pos)
  );

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    beat    = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = EMIT;
          clear   = 1'b1;
        end
      end
      EMIT: begin
        // Pad beats never wait on the source; interior beats need a handshake.
        if (!hold) begin
          s_ready = !is_pad;
          beat    = is_pad || s_valid;
          if (beat && last_pos) state_d = FLUSH;
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lb_valid_d   = beat;
    lb_act_d     = lb_act_q;
    if (beat) lb_act_d = is_pad ? '0 : s_act;
    lb_flush_d   = (state_q == FLUSH);
    frame_done_d = (state_q == FLUSH);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      lb_valid_q   <= 1'b0;
      lb_flush_q   <= 1'b0;
      frame_done_q <= 1'b0;
      lb_act_q     <= '0;
    end else begin
      state_q      <= state_d;
      lb_valid_q   <= lb_valid_d;
      lb_flush_q   <= lb_flush_d;
      frame_done_q <= frame_done_d;
      lb_act_q     <= lb_act_d;
    end
  end

  assign lb_valid   = lb_valid_q;
  assign lb_flush   = lb_flush_q;
  assign lb_act     = lb_act_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_act_stream_feeder.sv
// Scoreboard bench: dut_a is a 4x3 image with PAD=1, dut_b is a 2x2 image with PAD=0.
module tb_act_stream_feeder;

  localparam int W = 24;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic fs_a = 1'b0, hold_a = 1'b0, sv_a = 1'b0;
  logic sr_a, lbv_a, lbf_a, busy_a, fd_a;
  logic [W-1:0] sa_a = '0, lba_a;

  logic fs_b = 1'b0, hold_b = 1'b0, sv_b = 1'b0;
  logic sr_b, lbv_b, lbf_b, busy_b, fd_b;
  logic [W-1:0] sa_b = '0, lba_b;

  act_stream_feeder #(.NBITS(8), .NFMAPS(3), .IMAGE_SIZE_X(4), .IMAGE_SIZE_Y(3), .PAD(1)) dut_a (
    .clk(clk), .rstn(rstn), .frame_start(fs_a), .hold(hold_a), .s_valid(sv_a), .s_ready(sr_a),
    .s_act(sa_a), .lb_valid(lbv_a), .lb_flush(lbf_a), .lb_act(lba_a), .busy(busy_a),
    .frame_done(fd_a));

  act_stream_feeder #(.NBITS(8), .NFMAPS(3), .IMAGE_SIZE_X(2), .IMAGE_SIZE_Y(2), .PAD(0)) dut_b (
    .clk(clk), .rstn(rstn), .frame_start(fs_b), .hold(hold_b), .s_valid(sv_b), .s_ready(sr_b),
    .s_act(sa_b), .lb_valid(lbv_b), .lb_flush(lbf_b), .lb_act(lba_b), .busy(busy_b),
    .frame_done(fd_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pix(input int i);
    return 24'h102030 + 24'(i) * 24'h030303;
  endfunction

  // Padded 6x5 frame of a 4x3 image: -1 marks a zero pad beat, otherwise the input pixel index.
  int map_a[30] = '{-1, -1, -1, -1, -1, -1,
                    -1,  0,  1,  2,  3, -1,
                    -1,  4,  5,  6,  7, -1,
                    -1,  8,  9, 10, 11, -1,
                    -1, -1, -1, -1, -1, -1};

  logic [W-1:0] q_a[$];
  logic [W-1:0] q_b[$];
  int beats_a = 0, flush_a = 0, flush_cyc_a = 0;
  int beats_b = 0, flush_b = 0, flush_cyc_b = 0, srdy_b = 0;
  int beat_cyc_a[256];

  int mode_a = 0, epoch_a = 0;
  int mode_b = 0, epoch_b = 0;

  initial begin : mon_a
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (lbv_a) begin
          if (q_a.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_extra_beat: got beat %0d with no expected beat queued", lba_a);
          end else begin
            check($sformatf("a_beat%0d", beats_a), lba_a, q_a.pop_front());
          end
          if (beats_a < 256) beat_cyc_a[beats_a] = cyc;
          beats_a++;
        end
        if (lbf_a || fd_a) begin
          check("a_flush_eq_done", fd_a, lbf_a);
          check("a_flush_no_valid", lbv_a, 0);
          check("a_flush_after_all_beats", q_a.size(), 0);
          flush_a++;
          flush_cyc_a = cyc;
        end
      end
    end
  end

  initial begin : mon_b
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (sr_b) srdy_b++;
        if (lbv_b) begin
          if (q_b.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_extra_beat: got beat %0d with no expected beat queued", lba_b);
          end else begin
            check($sformatf("b_beat%0d", beats_b), lba_b, q_b.pop_front());
          end
          beats_b++;
        end
        if (lbf_b || fd_b) begin
          check("b_flush_eq_done", fd_b, lbf_b);
          check("b_flush_after_all_beats", q_b.size(), 0);
          flush_b++;
          flush_cyc_b = cyc;
        end
      end
    end
  end

  initial begin : src_a
    int idx = 0;
    int seen = 0;
    bit take;
    bit tog = 1'b0;
    forever begin
      @(negedge clk);
      take = sv_a && sr_a;
      @(posedge clk);
      #1;
      if (seen != epoch_a) begin
        seen = epoch_a;
        idx  = 0;
      end else if (take) begin
        idx++;
      end
      tog  = ~tog;
      sv_a = (mode_a == 1) || (mode_a == 2 && tog);
      sa_a = pix(idx);
    end
  end

  initial begin : src_b
    int idx = 0;
    int seen = 0;
    bit take;
    forever begin
      @(negedge clk);
      take = sv_b && sr_b;
      @(posedge clk);
      #1;
      if (seen != epoch_b) begin
        seen = epoch_b;
        idx  = 0;
      end else if (take) begin
        idx++;
      end
      sv_b = (mode_b == 1);
      sa_b = pix(idx);
    end
  end

  task automatic push_a();
    foreach (map_a[k]) q_a.push_back(map_a[k] < 0 ? 24'h0 : pix(map_a[k]));
  endtask

  task automatic start_a(output int sc);
    epoch_a++;
    @(posedge clk); #1 fs_a = 1'b1;
    @(posedge clk); #1 fs_a = 1'b0;
    sc = cyc;
  endtask

  task automatic start_b(output int sc);
    epoch_b++;
    @(posedge clk); #1 fs_b = 1'b1;
    @(posedge clk); #1 fs_b = 1'b0;
    sc = cyc;
  endtask

  task automatic wait_beats_a(input int n, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (beats_a >= n) return;
    end
    checks++;
    failures++;
    $display("FAIL %s: timeout, got %0d beats expected %0d", name, beats_a, n);
  endtask

  task automatic wait_flush_a(input int n, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (flush_a >= n) return;
    end
    checks++;
    failures++;
    $display("FAIL %s: timeout, got %0d flushes expected %0d", name, flush_a, n);
  endtask

  task automatic wait_flush_b(input int n, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (flush_b >= n) return;
    end
    checks++;
    failures++;
    $display("FAIL %s: timeout, got %0d flushes expected %0d", name, flush_b, n);
  endtask

  initial begin : main
    int sc, base, viol, b0, busy_cnt;

    repeat (3) @(posedge clk);
    #1;
    check("a_reset_outputs", {lbv_a, lbf_a, lba_a, busy_a, fd_a, sr_a}, 0);
    check("b_reset_outputs", {lbv_b, lbf_b, lba_b, busy_b, fd_b, sr_b}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Steady source, no stalls.
    mode_a = 1;
    base = beats_a;
    push_a();
    start_a(sc);
    wait_flush_a(1, 100, "t1_flush");
    check("t1_beats", beats_a - base, 30);
    check("t1_contiguous", beat_cyc_a[base+29] - beat_cyc_a[base], 29);
    check("t1_first_beat_latency", beat_cyc_a[base] - sc, 1);
    check("t1_flush_latency", flush_cyc_a - sc, 31);
    @(negedge clk); #1;
    check("t1_busy_after_flush", busy_a, 0);

    // Source valid toggles every other cycle.
    mode_a = 2;
    base = beats_a;
    push_a();
    start_a(sc);
    wait_flush_a(2, 200, "t2_flush");
    check("t2_beats", beats_a - base, 30);
    check("t2_pad_head_undelayed", beat_cyc_a[base+6] - beat_cyc_a[base], 6);
    check("t2_pad_tail_undelayed", beat_cyc_a[base+29] - beat_cyc_a[base+23], 6);
    check("t2_has_gaps", (beat_cyc_a[base+29] - beat_cyc_a[base]) > 29, 1);

    // Five-cycle hold mid-row.
    mode_a = 1;
    base = beats_a;
    push_a();
    start_a(sc);
    wait_beats_a(base + 14, 100, "t3_reach_beat14");
    @(posedge clk); #1 hold_a = 1'b1;
    viol = 0;
    b0 = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (sr_a) viol++;
      if (i >= 1 && lbv_a) viol++;
      if (i == 1) b0 = beats_a;
    end
    @(posedge clk); #1 hold_a = 1'b0;
    @(negedge clk); #1;
    check("t3_hold_stall_violations", viol, 0);
    check("t3_hold_freeze", beats_a - b0, 0);
    wait_flush_a(3, 100, "t3_flush");
    check("t3_beats", beats_a - base, 30);

    // PAD=0 pass-through.
    mode_b = 1;
    for (int i = 0; i < 4; i++) q_b.push_back(pix(i));
    start_b(sc);
    wait_flush_b(1, 50, "t4_flush");
    check("t4_beats", beats_b, 4);
    check("t4_sready_cycles", srdy_b, 4);
    check("t4_flush_latency", flush_cyc_b - sc, 5);

    // frame_start mid-frame and during FLUSH are both dropped.
    base = beats_a;
    push_a();
    start_a(sc);
    wait_beats_a(base + 10, 100, "t5_reach_beat10");
    @(posedge clk); #1 fs_a = 1'b1;
    @(posedge clk); #1 fs_a = 1'b0;
    wait_beats_a(base + 30, 100, "t5_reach_last_beat");
    check("t5_busy_in_flush", busy_a, 1);
    fs_a = 1'b1;
    @(posedge clk); #1 fs_a = 1'b0;
    wait_flush_a(4, 20, "t5_flush");
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (busy_a) busy_cnt++;
    end
    check("t5_no_restart", busy_cnt, 0);
    check("t5_single_flush", flush_a, 4);
    check("t5_beats", beats_a - base, 30);

    // Asynchronous reset mid-frame, then a clean frame.
    base = beats_a;
    push_a();
    start_a(sc);
    wait_beats_a(base + 12, 100, "t6_reach_beat12");
    rstn = 1'b0;
    #1;
    check("t6_reset_outputs", {lbv_a, lbf_a, lba_a, busy_a, fd_a, sr_a}, 0);
    q_a.delete();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_flush_on_reset", flush_a, 4);
    base = beats_a;
    push_a();
    start_a(sc);
    wait_flush_a(5, 100, "t6_flush");
    check("t6_beats", beats_a - base, 30);
    check("t6_flush_latency", flush_cyc_a - sc, 31);
    check("t6_b_single_flush", flush_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
